sipo_rx_ctrl: RTL and testbench

Serial-to-parallel receive controller. Sequences a WIDTH-bit serial-in/parallel-out shift register on a frame start and counts bit strobes. Transfers each completed word into a holding register and presents it on a valid/ready handshake. Sits between a bit-timing source, which supplies bit_en strobes, and any parallel consumer.

---
 rtl/sipo_rx_ctrl_pkg.sv | 19 +
 rtl/sipo_rx_ctrl_if.sv | 28 ++
 rtl/sipo_shreg.sv | 29 ++
 rtl/sipo_rx_ctrl.sv | 136 +++++++++++++
 tb/tb_sipo_rx_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sipo_rx_ctrl_pkg.sv
// Shared definitions for the serial-to-parallel receive controller:
// FSM state encoding and the bit-counter width helper.
package sipo_rx_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Counter must hold 0..width-1; keep at least one bit for degenerate widths.
  function automatic int bit_cnt_w(input int width);
    if (width < 2) begin
      return 1;
    end else begin
      return $clog2(width);
    end
  endfunction

endpackage

// File: rtl/sipo_rx_ctrl_if.sv
// Bit-side and parallel-side signals of the receive controller.
// The master modport drives the controls, the slave modport is the controller.
interface sipo_rx_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             abort;
  logic             bit_en;
  logic             D;
  logic             ready;
  logic             clr_ovr;
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             busy;
  logic             overrun;

  modport master (
    output start, abort, bit_en, D, ready, clr_ovr,
    input  data_out, valid, busy, overrun
  );

  modport slave (
    input  start, abort, bit_en, D, ready, clr_ovr,
    output data_out, valid, busy, overrun
  );

endinterface

// File: rtl/sipo_shreg.sv
// WIDTH-bit serial-in shift register, MSB first, with enable and
// synchronous clear.
module sipo_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Shift register: clear has priority over shifting.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= {r_q[WIDTH-2:0], i_d};
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Receive controller: frames WIDTH bit strobes into a word, then holds it in
// a double-buffered output register behind a valid/ready handshake.
module sipo_rx_ctrl
  import sipo_rx_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = bit_cnt_w(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  sipo_rx_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_shreg_clr;
  logic             w_shreg_en;
  logic             w_done;
  logic             w_ovr_set;
  logic [WIDTH-1:0] w_shreg_q;
  logic [WIDTH-1:0] w_word;
  logic             w_unused_msb;
  logic [WIDTH-1:0] r_data_out;
  logic             r_valid;
  logic             r_overrun;

  sipo_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_shreg_clr),
    .i_en  (w_shreg_en),
    .i_d   (bus.D),
    .o_q   (w_shreg_q)
  );

  // The completed word includes the bit arriving on the final strobe, so it is
  // taken from the shift register's next value; the oldest stored bit drops out.
  assign w_word       = {w_shreg_q[WIDTH-2:0], bus.D};
  assign w_unused_msb = w_shreg_q[WIDTH-1];

  // Next-state, counter and shift-register control.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shreg_clr = 1'b0;
    w_shreg_en  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          w_state_nxt = ST_SHIFT;
          w_cnt_nxt   = '0;
          w_shreg_clr = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bus.abort) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_shreg_clr = 1'b1;
        end else if (bus.bit_en) begin
          w_shreg_en = 1'b1;
          if (r_cnt == LAST_BIT) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_done      = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_shreg_clr = 1'b1;
      end
    endcase
  end

  // FSM state and bit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Holding register: a completed word is dropped if the previous one is stuck.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out <= '0;
      r_valid    <= 1'b0;
    end else if (w_done && (!r_valid || bus.ready)) begin
      r_data_out <= w_word;
      r_valid    <= 1'b1;
    end else if (r_valid && bus.ready) begin
      r_valid    <= 1'b0;
    end else begin
      r_valid    <= r_valid;
    end
  end

  assign w_ovr_set = w_done && r_valid && !bus.ready;

  // Sticky overrun; a new drop outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_set) begin
      r_overrun <= 1'b1;
    end else if (bus.clr_ovr) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_overrun;
    end
  end

  assign bus.data_out = r_data_out;
  assign bus.valid    = r_valid;
  assign bus.busy     = (r_state == ST_SHIFT);
  assign bus.overrun  = r_overrun;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Self-checking bench for sipo_rx_ctrl: directed scenarios plus a randomized
// run compared against a queue-based frame model.
module tb_sipo_rx_ctrl;

  localparam int WIDTH = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  sipo_rx_ctrl_if #(.WIDTH(WIDTH)) bus ();

  sipo_rx_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a frame is a queue of received bits; it completes at WIDTH bits.
  bit             m_busy;
  logic           m_bits[$];
  logic           m_valid;
  logic [WIDTH-1:0] m_data;
  logic           m_ovr;

  task automatic model_step();
    bit done;
    bit drop;
    logic [WIDTH-1:0] word;
    done = 1'b0;
    drop = 1'b0;
    word = '0;
    if (reset) begin
      m_busy = 1'b0; m_bits.delete(); m_valid = 1'b0; m_data = '0; m_ovr = 1'b0;
      return;
    end
    if (!m_busy) begin
      if (bus.start && !bus.abort) begin
        m_busy = 1'b1;
        m_bits.delete();
      end
    end else if (bus.abort) begin
      m_busy = 1'b0;
      m_bits.delete();
    end else if (bus.bit_en) begin
      m_bits.push_back(bus.D);
      if (m_bits.size() == WIDTH) begin
        for (int i = 0; i < WIDTH; i++) word[WIDTH-1-i] = m_bits[i];
        done = 1'b1;
        m_busy = 1'b0;
        m_bits.delete();
      end
    end
    if (done) begin
      if (!m_valid || bus.ready) begin
        m_data  = word;
        m_valid = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (m_valid && bus.ready) begin
      m_valid = 1'b0;
    end
    if (drop) m_ovr = 1'b1;
    else if (bus.clr_ovr) m_ovr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Send bits first..last of w (MSB first), with gap idle cycles after each strobe.
  task automatic send_bits(input logic [WIDTH-1:0] w, input int first, input int last, input int gap);
    for (int i = first; i <= last; i++) begin
      bus.bit_en = 1'b1;
      bus.D      = w[WIDTH-1-i];
      tick();
      bus.bit_en = 1'b0;
      bus.D      = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.valid); end
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", bus.data_out); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rst_ovr: got %b want 0", bus.overrun); end
    // Hold a word, create an overrun, then reset three bits into a further frame.
    bus.ready = 1'b0;
    pulse_start(); send_bits(8'h5A, 0, 7, 0);
    checks++; if (bus.data_out !== 8'h5A) begin errors++; $display("FAIL rst_pre_data: got %h want 5a", bus.data_out); end
    pulse_start(); send_bits(8'h77, 0, 7, 0);
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL rst_pre_ovr: got %b want 1", bus.overrun); end
    pulse_start(); send_bits(8'hE0, 0, 2, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", bus.valid); end
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h want 00", bus.data_out); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rst_mid_ovr: got %b want 0", bus.overrun); end
  endtask

  task automatic test_basic();
    bus.ready = 1'b1;
    pulse_start();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", bus.busy); end
    send_bits(8'hA5, 0, 6, 0);
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", bus.valid); end
    send_bits(8'hA5, 7, 7, 0);
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", bus.valid); end
    checks++; if (bus.data_out !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", bus.data_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b want 0", bus.busy); end
    tick();
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b want 0", bus.valid); end
  endtask

  task automatic test_gapped();
    bus.ready = 1'b0;
    pulse_start();
    send_bits(8'hA5, 0, 7, 2);
    checks++; if (bus.data_out !== 8'hA5) begin errors++; $display("FAIL gap_data: got %h want a5", bus.data_out); end
    repeat (5) tick();
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL gap_valid_hold: got %b want 1", bus.valid); end
    checks++; if (bus.data_out !== 8'hA5) begin errors++; $display("FAIL gap_data_hold: got %h want a5", bus.data_out); end
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL gap_valid_drop: got %b want 0", bus.valid); end
  endtask

  task automatic test_overrun();
    bus.ready = 1'b0;
    pulse_start(); send_bits(8'h3C, 0, 7, 0);
    pulse_start(); send_bits(8'hC3, 0, 7, 1);
    checks++; if (bus.data_out !== 8'h3C) begin errors++; $display("FAIL ovr_data_kept: got %h want 3c", bus.data_out); end
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b want 1", bus.valid); end
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", bus.overrun); end
    bus.clr_ovr = 1'b1; tick(); bus.clr_ovr = 1'b0;
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b want 0", bus.overrun); end
    pulse_start(); send_bits(8'hC3, 0, 6, 0);
    bus.ready = 1'b1;
    send_bits(8'hC3, 7, 7, 0);
    bus.ready = 1'b0;
    checks++; if (bus.data_out !== 8'hC3) begin errors++; $display("FAIL ovr_repl_data: got %h want c3", bus.data_out); end
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL ovr_repl_valid: got %b want 1", bus.valid); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_repl_ovr: got %b want 0", bus.overrun); end
    // Drop coinciding with a clear: the drop must win.
    pulse_start(); send_bits(8'h11, 0, 6, 0);
    bus.clr_ovr = 1'b1;
    send_bits(8'h11, 7, 7, 0);
    bus.clr_ovr = 1'b0;
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins: got %b want 1", bus.overrun); end
    checks++; if (bus.data_out !== 8'hC3) begin errors++; $display("FAIL ovr_set_wins_data: got %h want c3", bus.data_out); end
    bus.clr_ovr = 1'b1; bus.ready = 1'b1; tick(); bus.clr_ovr = 1'b0; tick();
  endtask

  task automatic test_abort();
    bus.ready = 1'b1;
    pulse_start(); send_bits(8'h5F, 0, 4, 0);
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", bus.valid); end
    checks++; if (bus.data_out !== 8'hC3) begin errors++; $display("FAIL abort_data_kept: got %h want c3", bus.data_out); end
    pulse_start(); send_bits(8'hFF, 0, 7, 0);
    checks++; if (bus.data_out !== 8'hFF) begin errors++; $display("FAIL abort_next_data: got %h want ff", bus.data_out); end
    tick();
    pulse_start(); send_bits(8'h81, 0, 6, 0);
    bus.abort = 1'b1;
    send_bits(8'h81, 7, 7, 0);
    bus.abort = 1'b0;
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL abort_last_valid: got %b want 0", bus.valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_last_busy: got %b want 0", bus.busy); end
    checks++; if (bus.data_out !== 8'hFF) begin errors++; $display("FAIL abort_last_data: got %h want ff", bus.data_out); end
  endtask

  task automatic test_ignored();
    bus.ready = 1'b1;
    pulse_start(); send_bits(8'h96, 0, 2, 0);
    pulse_start();
    send_bits(8'h96, 3, 6, 0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ign_still_busy: got %b want 1", bus.busy); end
    send_bits(8'h96, 7, 7, 0);
    checks++; if (bus.data_out !== 8'h96) begin errors++; $display("FAIL ign_start_data: got %h want 96", bus.data_out); end
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL ign_start_valid: got %b want 1", bus.valid); end
    tick();
    bus.start = 1'b1; bus.abort = 1'b1; tick(); bus.start = 1'b0; bus.abort = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ign_start_abort: got %b want 0", bus.busy); end
    send_bits(8'h24, 0, 7, 0);
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL ign_idle_bits: got %b want 0", bus.valid); end
    checks++; if (bus.data_out !== 8'h96) begin errors++; $display("FAIL ign_idle_data: got %h want 96", bus.data_out); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 499) == 0);
      bus.start   = ($urandom_range(0, 7) == 0);
      bus.abort   = ($urandom_range(0, 39) == 0);
      bus.bit_en  = ($urandom_range(0, 1) == 0);
      bus.D       = ($urandom_range(0, 1) == 0);
      bus.ready   = ($urandom_range(0, 2) == 0);
      bus.clr_ovr = ($urandom_range(0, 15) == 0);
      tick();
      checks++; if (bus.valid !== m_valid) begin errors++; $display("FAIL rnd_valid @%0d: got %b want %b", n, bus.valid, m_valid); end
      checks++; if (bus.data_out !== m_data) begin errors++; $display("FAIL rnd_data @%0d: got %h want %h", n, bus.data_out, m_data); end
      checks++; if (bus.busy !== m_busy) begin errors++; $display("FAIL rnd_busy @%0d: got %b want %b", n, bus.busy, m_busy); end
      checks++; if (bus.overrun !== m_ovr) begin errors++; $display("FAIL rnd_ovr @%0d: got %b want %b", n, bus.overrun, m_ovr); end
    end
    reset = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.bit_en = 1'b0; bus.D = 1'b0; bus.clr_ovr = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.bit_en = 1'b0;
    bus.D = 1'b0; bus.ready = 1'b0; bus.clr_ovr = 1'b0;
    m_busy = 1'b0; m_valid = 1'b0; m_data = '0; m_ovr = 1'b0;
    test_reset();
    test_basic();
    test_gapped();
    test_overrun();
    test_abort();
    test_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
